regfile_dump_reader: RTL and testbench

- Sequential reader for the 32x32 MIPS register file. On a start pulse it walks a register range through one regfile read port and captures each value.
- It streams each captured (address, data) pair out over a valid/ready interface to the debug/trace path.
- It snoops the regfile write port so a write landing in the capture cycle is reflected in the captured value.
- It sits beside the regfile and owns one read-address port (ra1 or ra2) while busy.

---
 rtl/regfile_dump_reader.sv | 94 +++++++++
 tb/tb_regfile_dump_reader.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks a register range through one regfile read port and
// streams each captured (address, data) pair over a valid/ready interface.
module regfile_dump_reader #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] first_reg,
    input  logic [AW-1:0] last_reg,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] ra,
    input  logic [DW-1:0] rd,
    input  logic          wen_snoop,
    input  logic [AW-1:0] wadd_snoop,
    input  logic [DW-1:0] wdata_snoop,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_addr,
    output logic [DW-1:0] out_data
);
    typedef enum logic [1:0] {IDLE, ADDR, VALID, DONE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d, ra_q, ra_d, addr_q, addr_d, span;
    logic [AW:0]   count_q, count_d;
    logic [DW-1:0] data_q, data_d, capture;

    assign span = last_reg - first_reg;
    // r0 is hardwired zero; a write landing this cycle beats the stale read port
    assign capture = (ptr_q == '0) ? '0 :
                     (wen_snoop && wadd_snoop == ptr_q) ? wdata_snoop : rd;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        ra_d    = ra_q;
        addr_d  = addr_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: if (start) begin
                ptr_d   = first_reg;
                count_d = {1'b0, span} + (AW+1)'(1);
                state_d = ADDR;
            end
            ADDR: begin
                ra_d    = ptr_q;
                addr_d  = ptr_q;
                data_d  = capture;
                state_d = VALID;
            end
            VALID: if (out_ready) begin
                if (count_q > (AW+1)'(1)) begin
                    count_d = count_q - (AW+1)'(1);
                    ptr_d   = ptr_q + AW'(1);
                    state_d = ADDR;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
        endcase
        if (abort && state_q != IDLE) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            count_q <= '0;
            ra_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            ra_q    <= ra_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;
    assign out_valid = state_q == VALID;
    assign ra        = (state_q == ADDR) ? ptr_q : ra_q;
    assign out_addr  = addr_q;
    assign out_data  = data_q;
endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader: directed and randomized scans checked against a
// beat-list model built from the register range and the capture priority rules.
module tb_regfile_dump_reader;
    logic        clk = 0, rst = 0, start = 0, abort = 0, wen_snoop = 0, out_ready = 0;
    logic [4:0]  first_reg = 0, last_reg = 0, wadd_snoop = 0;
    logic [31:0] wdata_snoop = 0;
    logic        busy, done, out_valid;
    logic [4:0]  ra, out_addr;
    logic [31:0] rd, out_data;
    logic [31:0] rf [32];
    int          tests = 0, failed = 0;

    assign rd = rf[ra];
    always #5 clk = ~clk;

    regfile_dump_reader dut (
        .clk(clk), .rst(rst), .start(start), .first_reg(first_reg), .last_reg(last_reg),
        .abort(abort), .busy(busy), .done(done), .ra(ra), .rd(rd),
        .wen_snoop(wen_snoop), .wadd_snoop(wadd_snoop), .wdata_snoop(wdata_snoop),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_val(input logic [4:0] a);
        if (a == 0) return 0;
        if (wen_snoop && wadd_snoop == a) return wdata_snoop;
        return rf[a];
    endfunction

    // mode 0: ready held high (except the hold window); mode 1: random ready plus start noise
    task automatic scan(input logic [4:0] f, input logic [4:0] l, input int mode, input int hold_beat);
        int n, idx, cyc, held;
        logic [4:0] a;
        bit fin, hs;
        n = ((int'(l) - int'(f) + 32) % 32) + 1;
        idx = 0; cyc = 0; held = 0; fin = 0;
        first_reg = f; last_reg = l; start = 1;
        step();
        start = 0;
        chk("start_busy", 32'(busy), 1);
        chk("start_ra", 32'(ra), 32'(f));
        chk("start_valid", 32'(out_valid), 0);
        while (!fin && cyc < 1000) begin
            a = 5'(int'(f) + idx);
            if (idx == hold_beat && held < 5) begin
                out_ready = 0;
                if (out_valid) held++;
            end else begin
                out_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            end
            if (mode != 0) begin
                start = 1'($urandom_range(0, 1));
                first_reg = 5'($urandom);
                last_reg = 5'($urandom);
            end
            if (out_valid) begin
                chk("beat_addr", 32'(out_addr), 32'(a));
                chk("beat_data", out_data, exp_val(a));
                chk("beat_ra", 32'(ra), 32'(a));
            end
            hs = out_valid && out_ready;
            step();
            cyc++;
            if (hs) idx++;
            fin = done;
        end
        chk("beat_count", idx, n);
        chk("done_pulse", 32'(done), 1);
        chk("done_busy", 32'(busy), 1);
        if (mode == 0) chk("scan_cycles", cyc, 2 * n + held);
        start = (mode != 0);
        first_reg = 5'($urandom);
        step();
        start = 0;
        chk("done_once", 32'(done), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_valid", 32'(out_valid), 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        step();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_ra", 32'(ra), 0);
        chk("rst_addr", 32'(out_addr), 0);
        chk("rst_data", out_data, 0);
        rst = 1;
        step();
        chk("rst_idle", 32'(busy), 0);

        rf[1] = 4; rf[2] = 7; rf[3] = 9;
        scan(1, 3, 0, -1);

        rf[31] = 7;
        scan(31, 1, 0, -1);
        rf[0] = 1; wen_snoop = 1; wadd_snoop = 0; wdata_snoop = 1;
        scan(31, 1, 0, -1);
        wen_snoop = 0;

        scan(4, 7, 0, 1);

        rf[5] = 32'hdead_beef; wen_snoop = 1; wadd_snoop = 5; wdata_snoop = 32'h0000_0111;
        scan(5, 5, 0, -1);
        chk("snoop_value", out_data, 32'h0000_0111);
        wadd_snoop = 6;
        scan(5, 6, 0, -1);
        wen_snoop = 0;

        scan(9, 8, 0, -1);

        first_reg = 10; last_reg = 13; start = 1;
        step();
        start = 0; out_ready = 1;
        step();
        step();
        out_ready = 0;
        step();
        chk("abort_beat2_addr", 32'(out_addr), 11);
        chk("abort_beat2_valid", 32'(out_valid), 1);
        abort = 1; start = 1; first_reg = 0;
        step();
        chk("abort_busy", 32'(busy), 0);
        chk("abort_valid", 32'(out_valid), 0);
        chk("abort_done", 32'(done), 0);
        abort = 0; start = 0;
        step();
        chk("abort_no_done", 32'(done), 0);
        chk("abort_idle", 32'(busy), 0);

        first_reg = 2; last_reg = 6; start = 1;
        step();
        start = 0; out_ready = 0;
        step();
        chk("pre_rst_valid", 32'(out_valid), 1);
        #2 rst = 0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_ra", 32'(ra), 0);
        chk("arst_data", out_data, 0);
        @(negedge clk) rst = 1;
        out_ready = 1;
        step();
        step();
        chk("arst_stays_idle", 32'(busy), 0);
        chk("arst_no_valid", 32'(out_valid), 0);

        repeat (8) begin
            for (int i = 0; i < 32; i++) rf[i] = $urandom;
            wen_snoop = 1'($urandom_range(0, 1));
            wadd_snoop = 5'($urandom);
            wdata_snoop = $urandom;
            scan(5'($urandom), 5'($urandom), 1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
